vector_accumulator: RTL

- Integrates the scalar sum stream produced by the adder tree over a programmable number of samples and emits one accumulated result per frame.
- Sits directly downstream of the adder tree: its `din`/`sync` connect to the tree's `dout`/`sync_out`.
- Accepts one sample every clock with no backpressure, aligns frames to `sync`, and flags wrap-around overflow and discarded partial frames.

---
 rtl/vector_accumulator_pkg.sv | 21 ++
 rtl/vector_accumulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vector_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// vector_accumulator_pkg
// Shared definitions for the vector accumulator that sits behind the adder tree.
//   - Default width parameters, matching the tree's default output stream.
//   - acc_flags_t: the single-cycle status strobes that go out with each result.
// -----------------------------------------------------------------------------
package vector_accumulator_pkg;

  localparam int VA_INPUT_WIDTH   = 7;
  localparam int VA_OUTPUT_WIDTH  = 32;
  localparam int VA_ACC_LEN_BITS  = 8;

  // Output strobes registered together so they always land in the same cycle.
  typedef struct packed {
    logic valid;
    logic sync_out;
    logic overflow;
    logic resync;
  } acc_flags_t;

endpackage : vector_accumulator_pkg

// File: rtl/vector_accumulator.sv
// -----------------------------------------------------------------------------
// vector_accumulator
// Integrates the scalar sum stream from the adder tree over acc_len+1 samples
// and emits one accumulated result per frame. Frames are aligned to sync and
// restart back-to-back after each dump, with no idle cycles in between.
//
// Ports
//   clk       in  1              rising-edge clock
//   rst_n     in  1              asynchronous active-low reset
//   sync      in  1              pulse marking the first sample of a frame
//   din       in  INPUT_WIDTH    sample, valid every cycle
//   acc_len   in  ACC_LEN_BITS   samples per dump minus one (latched at sync)
//   dout      out OUTPUT_WIDTH   accumulated result, held between strobes
//   valid     out 1              one-cycle strobe qualifying dout
//   sync_out  out 1              set on the first valid after each sync
//   overflow  out 1              dumped frame wrapped (aligned with valid)
//   resync    out 1              partial frame discarded by an early sync
// -----------------------------------------------------------------------------
module vector_accumulator
  import vector_accumulator_pkg::*;
#(
  parameter int    INPUT_WIDTH  = VA_INPUT_WIDTH,
  parameter int    OUTPUT_WIDTH = VA_OUTPUT_WIDTH,
  parameter int    ACC_LEN_BITS = VA_ACC_LEN_BITS,
  parameter string IS_SIGNED    = "TRUE"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync,
  input  logic [INPUT_WIDTH-1:0]  din,
  input  logic [ACC_LEN_BITS-1:0] acc_len,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    valid,
  output logic                    sync_out,
  output logic                    overflow,
  output logic                    resync
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_ACCUM   = 1'b1;
  localparam bit   SIGNED_EXT = (IS_SIGNED == "TRUE");
  // One extra bit so a full 2^ACC_LEN_BITS-sample frame is countable.
  localparam int   CNT_W      = ACC_LEN_BITS + 1;

  // Sign- or zero-extend a tree sample to the accumulator width.
  function automatic logic signed [OUTPUT_WIDTH-1:0] ext_din(
    input logic [INPUT_WIDTH-1:0] d
  );
    logic signed [OUTPUT_WIDTH-1:0] r;
    r = '0;
    r[INPUT_WIDTH-1:0] = d;
    for (int i = INPUT_WIDTH; i < OUTPUT_WIDTH; i++) begin
      r[i] = SIGNED_EXT ? d[INPUT_WIDTH-1] : 1'b0;
    end
    return r;
  endfunction

  // Wrap detection for one accumulate step: sign flip on like-signed operands
  // in signed mode, carry out of the top bit in unsigned mode.
  function automatic logic add_ovf(
    input logic signed [OUTPUT_WIDTH-1:0] a,
    input logic signed [OUTPUT_WIDTH-1:0] b,
    input logic signed [OUTPUT_WIDTH-1:0] s
  );
    logic [OUTPUT_WIDTH:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    if (SIGNED_EXT) begin
      return (a[OUTPUT_WIDTH-1] == b[OUTPUT_WIDTH-1]) &&
             (s[OUTPUT_WIDTH-1] != a[OUTPUT_WIDTH-1]);
    end
    return wide[OUTPUT_WIDTH];
  endfunction

  logic                           state_q;
  logic                           state_d;

  logic signed [OUTPUT_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [ACC_LEN_BITS-1:0]        len_q;
  logic                           ovf_q;
  logic                           pend_q;
  logic [OUTPUT_WIDTH-1:0]        dout_q;
  acc_flags_t                     flags_q;

  logic                           take_p0;
  logic signed [OUTPUT_WIDTH-1:0] din_x_p0;
  logic signed [OUTPUT_WIDTH-1:0] base_p0;
  logic signed [OUTPUT_WIDTH-1:0] sum_p0;
  logic [ACC_LEN_BITS-1:0]        len_p0;
  logic [CNT_W-1:0]               cnt_nxt_p0;
  logic                           ovf_p0;
  logic                           pend_p0;
  logic                           vld_p0;
  logic                           drop_p0;
  acc_flags_t                     flags_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Once a sync has been seen the block never returns to IDLE; frames keep
  // auto-restarting until the next reset.
  always_comb begin
    state_d = state_q;
    if (sync) begin
      state_d = ST_ACCUM;
    end
  end

  // Stage p0: accumulate decision for the current sample
  always_comb begin
    take_p0    = sync || (state_q == ST_ACCUM);
    din_x_p0   = ext_din(din);
    // A sync restarts the frame, so the running sum starts from zero.
    base_p0    = sync ? '0 : acc_q;
    sum_p0     = base_p0 + din_x_p0;
    len_p0     = sync ? acc_len : len_q;
    cnt_nxt_p0 = sync ? CNT_W'(1) : cnt_q + CNT_W'(1);
    ovf_p0     = add_ovf(base_p0, din_x_p0, sum_p0) | (ovf_q & ~sync);
    pend_p0    = sync | pend_q;
    vld_p0     = take_p0 && (cnt_nxt_p0 == ({1'b0, len_p0} + CNT_W'(1)));
    // A sync in ACCUM drops whatever partial frame is in flight; cnt_q is
    // zero right after a dump, so a sync that lands on a frame boundary is
    // not reported.
    drop_p0    = sync && (state_q == ST_ACCUM) && (cnt_q != '0);

    flags_d          = '0;
    flags_d.valid    = vld_p0;
    flags_d.sync_out = vld_p0 & pend_p0;
    flags_d.overflow = vld_p0 & ovf_p0;
    flags_d.resync   = drop_p0;
  end

  // Stage p1: registered accumulator state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
      if (vld_p0) begin
        dout_q <= sum_p0;
      end
      if (take_p0) begin
        if (sync) begin
          len_q <= acc_len;
        end
        if (vld_p0) begin
          acc_q  <= '0;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
          pend_q <= 1'b0;
        end else begin
          acc_q  <= sum_p0;
          cnt_q  <= cnt_nxt_p0;
          ovf_q  <= ovf_p0;
          pend_q <= pend_p0;
        end
      end
    end
  end

  assign dout     = dout_q;
  assign valid    = flags_q.valid;
  assign sync_out = flags_q.sync_out;
  assign overflow = flags_q.overflow;
  assign resync   = flags_q.resync;

endmodule : vector_accumulator
